// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu
//  Description : Multi-cycle integer execution unit. Single-cycle ALU ops plus
//                RV32M-style multiply (shift-add) and optional restoring
//                divide/remainder, one operation per valid/ready handshake.
//                Define SEQ_ALU_DIV_EN to build the divide datapath; without
//                it, ops 13-16 are reported as illegal.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic            busy
);

    localparam int        c_cw       = $clog2(XLEN);
    localparam logic [c_cw-1:0] c_last = c_cw'(XLEN - 1);

    localparam logic [4:0] c_op_add   = 5'd0;
    localparam logic [4:0] c_op_sub   = 5'd1;
    localparam logic [4:0] c_op_and   = 5'd2;
    localparam logic [4:0] c_op_or    = 5'd3;
    localparam logic [4:0] c_op_xor   = 5'd4;
    localparam logic [4:0] c_op_slt   = 5'd5;
    localparam logic [4:0] c_op_sltu  = 5'd6;
    localparam logic [4:0] c_op_sll   = 5'd7;
    localparam logic [4:0] c_op_srl   = 5'd8;
    localparam logic [4:0] c_op_sra   = 5'd9;
    localparam logic [4:0] c_op_mul   = 5'd10;
    localparam logic [4:0] c_op_mulh  = 5'd11;
    localparam logic [4:0] c_op_mulhu = 5'd12;
`ifdef SEQ_ALU_DIV_EN
    localparam logic [4:0] c_op_div   = 5'd13;
    localparam logic [4:0] c_op_divu  = 5'd14;
    localparam logic [4:0] c_op_rem   = 5'd15;
    localparam logic [4:0] c_op_remu  = 5'd16;
`endif

`ifdef SEQ_ALU_DIV_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd3} state_t;
`endif

    state_t                r_state, w_next, w_target;
    logic [4:0]            r_op;
    logic [2*XLEN-1:0]     r_acc;    // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
    logic [XLEN-1:0]       r_opb;    // MUL: multiplicand magnitude; DIV: divisor magnitude
    logic [c_cw-1:0]       r_cnt;
    logic                  r_neg;
    logic [XLEN-1:0]       r_result;
    logic                  r_zero, r_illegal;

    logic                  w_accept, w_is_alu, w_is_mul, w_legal, w_signed;
    logic                  w_s1_neg, w_s2_neg;
    logic [XLEN-1:0]       w_mag1, w_mag2, w_alu, w_imm_res, w_mul_res;
    logic [c_cw-1:0]       w_shamt;
    logic [XLEN:0]         w_mul_sum;
    logic [2*XLEN-1:0]     w_mul_next, w_prod;

`ifdef SEQ_ALU_DIV_EN
    logic                  r_rneg;
    logic                  w_is_div, w_div_zero, w_div_ovf, w_div_special, w_is_quo;
    logic [XLEN:0]         w_div_shift, w_div_diff;
    logic [2*XLEN-1:0]     w_div_next;
    logic [XLEN-1:0]       w_quo, w_rem, w_div_res;
`endif

    assign w_accept  = in_valid && in_ready;
    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign illegal   = r_illegal;
`ifdef SEQ_ALU_DIV_EN
    assign busy      = (r_state == S_MUL) || (r_state == S_DIV);
`else
    assign busy      = (r_state == S_MUL);
`endif

    // Operation decode, operand magnitudes and single-cycle results
    always_comb begin
        w_shamt  = src2[c_cw-1:0];
        w_is_alu = (op <= c_op_sra);
        w_is_mul = (op >= c_op_mul) && (op <= c_op_mulhu);
`ifdef SEQ_ALU_DIV_EN
        w_is_div      = (op >= c_op_div) && (op <= c_op_remu);
        w_is_quo      = (op == c_op_div) || (op == c_op_divu);
        w_signed      = (op == c_op_mulh) || (op == c_op_div) || (op == c_op_rem);
        w_div_zero    = (src2 == {XLEN{1'b0}});
        w_div_ovf     = ((op == c_op_div) || (op == c_op_rem)) &&
                        (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == {XLEN{1'b1}});
        w_div_special = w_is_div && (w_div_zero || w_div_ovf);
        w_legal       = w_is_alu || w_is_mul || w_is_div;
`else
        w_signed = (op == c_op_mulh);
        w_legal  = w_is_alu || w_is_mul;
`endif
        w_s1_neg = w_signed && src1[XLEN-1];
        w_s2_neg = w_signed && src2[XLEN-1];
        w_mag1   = w_s1_neg ? ({XLEN{1'b0}} - src1) : src1;
        w_mag2   = w_s2_neg ? ({XLEN{1'b0}} - src2) : src2;

        case (op)
            c_op_add:  w_alu = src1 + src2;
            c_op_sub:  w_alu = src1 - src2;
            c_op_and:  w_alu = src1 & src2;
            c_op_or:   w_alu = src1 | src2;
            c_op_xor:  w_alu = src1 ^ src2;
            c_op_slt:  w_alu = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
            c_op_sltu: w_alu = {{(XLEN-1){1'b0}}, (src1 < src2)};
            c_op_sll:  w_alu = src1 << w_shamt;
            c_op_srl:  w_alu = src1 >> w_shamt;
            c_op_sra:  w_alu = $signed(src1) >>> w_shamt;
            default:   w_alu = {XLEN{1'b0}};
        endcase

        w_imm_res = w_legal ? w_alu : {XLEN{1'b0}};
`ifdef SEQ_ALU_DIV_EN
        if (w_is_div && w_div_zero)
            w_imm_res = w_is_quo ? {XLEN{1'b1}} : src1;
        else if (w_is_div && w_div_ovf)
            w_imm_res = w_is_quo ? src1 : {XLEN{1'b0}};
`endif

        w_target = S_DONE;
        if (w_is_mul)
            w_target = S_MUL;
`ifdef SEQ_ALU_DIV_EN
        else if (w_is_div && !w_div_special)
            w_target = S_DIV;
`endif
    end

    // One iteration step of each engine, plus the sign fix-up used on the last step
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_opb : {XLEN{1'b0}})};
        w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
        w_prod     = r_neg ? ({(2*XLEN){1'b0}} - w_mul_next) : w_mul_next;
        w_mul_res  = (r_op == c_op_mul) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
`ifdef SEQ_ALU_DIV_EN
        w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_div_diff  = w_div_shift - {1'b0, r_opb};
        w_div_next  = {(w_div_diff[XLEN] ? w_div_shift[XLEN-1:0] : w_div_diff[XLEN-1:0]),
                       r_acc[XLEN-2:0], ~w_div_diff[XLEN]};
        w_quo       = w_div_next[XLEN-1:0];
        w_rem       = w_div_next[2*XLEN-1:XLEN];
        if ((r_op == c_op_div) || (r_op == c_op_divu))
            w_div_res = r_neg ? ({XLEN{1'b0}} - w_quo) : w_quo;
        else
            w_div_res = r_rneg ? ({XLEN{1'b0}} - w_rem) : w_rem;
`endif
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = w_target;
            S_MUL:   if (r_cnt == c_last) w_next = S_DONE;
`ifdef SEQ_ALU_DIV_EN
            S_DIV:   if (r_cnt == c_last) w_next = S_DONE;
`endif
            S_DONE:  begin
                if (w_accept)
                    w_next = w_target;
                else if (out_ready)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Operand capture, iteration datapath and registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= 5'd0;
            r_acc     <= {(2*XLEN){1'b0}};
            r_opb     <= {XLEN{1'b0}};
            r_cnt     <= {c_cw{1'b0}};
            r_neg     <= 1'b0;
            r_result  <= {XLEN{1'b0}};
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            r_rneg    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_op  <= op;
            r_cnt <= {c_cw{1'b0}};
            r_neg <= w_s1_neg ^ w_s2_neg;
`ifdef SEQ_ALU_DIV_EN
            r_rneg <= w_s1_neg;
`endif
            if (w_is_mul) begin
                r_acc <= {{XLEN{1'b0}}, w_mag2};
                r_opb <= w_mag1;
            end else begin
                r_acc <= {{XLEN{1'b0}}, w_mag1};
                r_opb <= w_mag2;
            end
            if (w_target == S_DONE) begin
                r_result  <= w_imm_res;
                r_zero    <= (w_imm_res == {XLEN{1'b0}});
                r_illegal <= !w_legal;
            end
        end else if (r_state == S_MUL) begin
            r_acc <= w_mul_next;
            r_cnt <= r_cnt + c_cw'(1);
            if (r_cnt == c_last) begin
                r_result  <= w_mul_res;
                r_zero    <= (w_mul_res == {XLEN{1'b0}});
                r_illegal <= 1'b0;
            end
`ifdef SEQ_ALU_DIV_EN
        end else if (r_state == S_DIV) begin
            r_acc <= w_div_next;
            r_cnt <= r_cnt + c_cw'(1);
            if (r_cnt == c_last) begin
                r_result  <= w_div_res;
                r_zero    <= (w_div_res == {XLEN{1'b0}});
                r_illegal <= 1'b0;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_alu
//  Description : Directed self-checking bench for seq_alu (XLEN = 32).
//                Expected values are hand-computed constants. Divide vectors
//                depend on whether SEQ_ALU_DIV_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [4:0]  op;
    logic [31:0] src1, src2, result;
    logic        zero, illegal, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_alu #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from idle, measure latency and busy cycles, check outputs, then hand off
    task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input logic exp_ill, input int exp_lat);
        int lat;
        int nbusy;
        op = o; src1 = a; src2 = b; in_valid = 1'b1; out_ready = 1'b0;
        check({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0; src1 = ~a; src2 = ~b; op = 5'd0;
        lat = 1; nbusy = 0;
        while (!out_valid && lat < 100) begin
            if (busy) nbusy++;
            tick();
            lat++;
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".busy_cycles"}, nbusy, exp_lat - 1);
        check({tag, ".result"}, result, exp);
        check({tag, ".zero"}, {31'b0, zero}, {31'b0, (exp == 32'd0)});
        check({tag, ".illegal"}, {31'b0, illegal}, {31'b0, exp_ill});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".handoff"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 5'd0; src1 = 32'd0; src2 = 32'd0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Leave a result pending, then reset asynchronously
        op = 5'd0; src1 = 32'd1; src2 = 32'd2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("pend.out_valid", {31'b0, out_valid}, 32'd1);
        check("pend.result", result, 32'd3);
        rst_n = 1'b0;
        #1;
        check("rst.out_valid", {31'b0, out_valid}, 32'd0);
        check("rst.result", result, 32'd0);
        check("rst.zero", {31'b0, zero}, 32'd0);
        check("rst.illegal", {31'b0, illegal}, 32'd0);
        check("rst.busy", {31'b0, busy}, 32'd0);
        check("rst.in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // Single-cycle ALU ops
        run_op("add",  5'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1);
        run_op("sub",  5'd1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1);
        run_op("xor",  5'd4, 32'hF0F0_1234, 32'hFFFF_1234, 32'h0F0F_0000, 1'b0, 1);
        run_op("sll",  5'd7, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0, 1);
        run_op("srl",  5'd8, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1);

        // Back-to-back SRA, SLTU, SLT with out_ready held high
        out_ready = 1'b1;
        op = 5'd9; src1 = 32'h8000_0000; src2 = 32'd31; in_valid = 1'b1;
        tick();
        check("b2b.sra.valid", {31'b0, out_valid}, 32'd1);
        check("b2b.sra.result", result, 32'hFFFF_FFFF);
        check("b2b.in_ready", {31'b0, in_ready}, 32'd1);
        op = 5'd6; src1 = 32'd1; src2 = 32'hFFFF_FFFF;
        tick();
        check("b2b.sltu.valid", {31'b0, out_valid}, 32'd1);
        check("b2b.sltu.result", result, 32'd1);
        op = 5'd5; src1 = 32'd1; src2 = 32'hFFFF_FFFF;
        tick();
        in_valid = 1'b0;
        check("b2b.slt.valid", {31'b0, out_valid}, 32'd1);
        check("b2b.slt.result", result, 32'd0);
        check("b2b.slt.zero", {31'b0, zero}, 32'd1);
        tick();
        out_ready = 1'b0;
        check("b2b.drain", {31'b0, out_valid}, 32'd0);

        // Multiply
        run_op("mulh",  5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 33);
        run_op("mul",   5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33);
        run_op("mulhu", 5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
        run_op("mulh2", 5'd11, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 33);

        // Divide, or its absence
`ifdef SEQ_ALU_DIV_EN
        run_op("div",     5'd13, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 33);
        run_op("rem",     5'd15, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 33);
        run_op("divu",    5'd14, 32'd100,       32'd7,         32'd14,        1'b0, 33);
        run_op("divu0",   5'd14, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 1);
        run_op("remu0",   5'd16, 32'd5,         32'd0,         32'd5,         1'b0, 1);
        run_op("div_ovf", 5'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
        run_op("rem_ovf", 5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1);
`else
        run_op("div_off", 5'd13, 32'd6, 32'd3, 32'd0, 1'b1, 1);
        run_op("rem_off", 5'd16, 32'd6, 32'd4, 32'd0, 1'b1, 1);
`endif
        run_op("op31", 5'd31, 32'd9, 32'd9, 32'd0, 1'b1, 1);

        // Backpressure: completed MUL held for 10 cycles
        op = 5'd10; src1 = 32'd3; src2 = 32'd5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 100) begin
            tick();
            cnt++;
        end
        for (int i = 0; i < 10; i++) begin
            check("bp.result", result, 32'd15);
            check("bp.in_ready", {31'b0, in_ready}, 32'd0);
            check("bp.out_valid", {31'b0, out_valid}, 32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of a MUL discards it
        op = 5'd10; src1 = 32'd7; src2 = 32'd9; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        check("midrst.busy_before", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst.busy", {31'b0, busy}, 32'd0);
        check("midrst.in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid || busy) cnt++;
            tick();
        end
        check("midrst.no_output", cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_alu.md
# seq_alu

Multi-cycle, parametrised integer execution unit extending the single-cycle ALU with RV32M-style multiply and divide/remainder. It sits in the execute stage and accepts one operation per valid/ready handshake. Single-cycle ops return after one cycle; multiply and divide iterate one bit per cycle. Divide support is a compile-time option.

## Interface
Parameters:
- XLEN, 32, operand/result width; power of two, ≥ 8.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request valid
- in_ready  out  1  unit can accept an operation this cycle
- op  in  5  operation code (see Operation)
- src1  in  XLEN  first operand (rs1)
- src2  in  XLEN  second operand (rs2 / immediate)
- out_valid  out  1  result valid, held until out_ready
- out_ready  in  1  consumer takes result
- result  out  XLEN  registered result
- zero  out  1  result == 0, qualified by out_valid
- illegal  out  1  op was unsupported, qualified by out_valid
- busy  out  1  iteration in progress (MUL or DIV state)

## Operation
- op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 MUL, 11 MULH, 12 MULHU, 13 DIV, 14 DIVU, 15 REM, 16 REMU; 17–31 illegal.
- Handshake: transfer when in_valid && in_ready. src1/src2/op are captured at transfer; later input changes are ignored.
- in_ready = (state == IDLE) || (state == DONE && out_ready).
- States: IDLE, MUL, DIV, DONE.
  - IDLE: accept ALU op or illegal op → DONE; MUL/MULH/MULHU → MUL; div/rem → DIV, except special cases, which go → DONE.
  - MUL: XLEN iterations, then → DONE.
  - DIV: XLEN iterations, then → DONE.
  - DONE: out_valid = 1. On out_ready → IDLE, or directly into the next op if one is accepted in the same cycle.
- ALU ops:
  - Shifts use src2[$clog2(XLEN)-1:0].
  - SLT is signed; SLTU is unsigned.
  - SRA is arithmetic.
  - All arithmetic is mod 2^XLEN.
- Multiply: shift-add on magnitudes over a 2·XLEN product.
  - MUL returns low XLEN bits.
  - MULH (signed×signed) and MULHU return the high XLEN bits.
  - The sign is applied by negating the 2·XLEN product after the last iteration.
- Divide: restoring, on magnitudes.
  - DIV/REM are signed: quotient negated if signs differ; remainder takes the dividend's sign.
  - Divide by zero: quotient = all ones; remainder = src1.
  - Signed overflow (src1 = −2^(XLEN−1), src2 = −1): quotient = src1; remainder = 0.
- Illegal op: result = 0, zero = 1, illegal = 1.
- zero and illegal are registered together with result.

## Timing
- Reset (async, immediate): state = IDLE; out_valid, result, zero, illegal, busy = 0; in_ready = 1. Reset mid-iteration discards the operation.
- Latency counts from the transfer edge to the first out_valid cycle:
  - ALU ops, illegal ops, div special cases: 1 cycle.
  - MUL*, and DIV*/REM* (when DIV_EN is set): XLEN+1 cycles.
- Back-to-back: out_ready = 1 with in_valid = 1 in DONE hands off the result and accepts the new op on the same edge. Sustained throughput is 1 ALU op per cycle.
- Backpressure: with out_ready = 0, DONE holds result, zero and illegal stable, and in_ready = 0.
- busy is high exactly during the MUL and DIV states.

## Configuration
- SEQ_ALU_DIV_EN defined: ops 13–16 are implemented as above, using the DIV state, dividend/remainder registers and the iteration counter.
- SEQ_ALU_DIV_EN undefined: the DIV state and its datapath are absent. Ops 13–16 are treated as illegal: 1-cycle latency, result 0, illegal = 1.

## Test plan
- Reset with out_valid pending → all outputs 0, in_ready = 1. Then ADD 0x7FFFFFFF + 1 → 0x80000000 one cycle after transfer, zero = 0.
- SRA 0x80000000 by 31 → 0xFFFFFFFF. SLTU 1 < 0xFFFFFFFF → 1. SLT 1 < 0xFFFFFFFF → 0. These three issued back-to-back with out_ready = 1 return on consecutive cycles.
- MULH 0xFFFFFFFF × 0xFFFFFFFF → 0; MUL → 1; MULHU → 0xFFFFFFFE. Each has out_valid exactly 33 cycles after transfer and busy high for 32 cycles.
- With SEQ_ALU_DIV_EN defined:
  - DIV −7 / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - DIVU 5 / 0 → 0xFFFFFFFF (1-cycle); REMU 5 / 0 → 5.
  - DIV 0x80000000 / −1 → 0x80000000; REM → 0 with zero = 1.
- Without the macro, DIV 6 / 3 → result 0, illegal = 1, 1-cycle. op 31 → illegal = 1 in either build.
- Backpressure: hold out_ready = 0 for 10 cycles after a MUL completes → result stable, in_ready = 0. Assert rst_n mid-MUL → IDLE next, no out_valid.
